// File: rtl/ptm_pkg.sv
// rtl/ptm_pkg.sv - shared types, default sizes and guard width helper for ptm_window
package ptm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 10;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_PAT_LEN = 4;

  // Guard and fill counters must hold PAT_LEN-1; never narrower than one bit.
  function automatic int guard_w(input int pat_len);
    return ($clog2(pat_len) < 1) ? 1 : $clog2(pat_len);
  endfunction

endpackage

// File: rtl/ptm_window_cmp.sv
// rtl/ptm_window_cmp.sv - combinational window-versus-pattern equality
// PTM_MASK_EN adds pat_mask: a 1 bit makes that pattern bit don't-care.
module ptm_window_cmp
  import ptm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic [(PAT_LEN > 1 ? PAT_LEN - 1 : 1)*DATA_W-1:0] hist,
  input  logic [DATA_W-1:0]                                 data,
  input  logic [PAT_LEN*DATA_W-1:0]                         pattern,
`ifdef PTM_MASK_EN
  input  logic [PAT_LEN*DATA_W-1:0]                         pat_mask,
`endif
  output logic                                              eq
);

  logic [PAT_LEN*DATA_W-1:0] win;

  // Oldest word sits in the low bits, matching the pattern element order.
  if (PAT_LEN > 1) begin : g_win
    assign win = {data, hist};
  end else begin : g_win1
    assign win = data;
  end

`ifdef PTM_MASK_EN
  assign eq = (((win ^ pattern) & ~pat_mask) == '0);
`else
  assign eq = (win == pattern);
`endif

endmodule

// File: rtl/ptm_window.sv
// rtl/ptm_window.sv - streams len words and counts PAT_LEN-word pattern matches
// Optional macro PTM_MASK_EN adds the pat_mask don't-care input.
module ptm_window
  import ptm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PAT_LEN*DATA_W-1:0] pattern,
`ifdef PTM_MASK_EN
  input  logic [PAT_LEN*DATA_W-1:0] pat_mask,
`endif
  input  logic [ADDR_W:0]           len,
  input  logic                      overlap,
  input  logic [DATA_W-1:0]         data,
  output logic                      en,
  output logic [ADDR_W-1:0]         addr,
  output logic                      flag,
  output logic                      fin,
  output logic [ADDR_W:0]           result
);

  localparam int GW = guard_w(PAT_LEN);
  localparam int HW = (PAT_LEN > 1 ? PAT_LEN - 1 : 1) * DATA_W;
  localparam logic [GW-1:0] FILL_MAX = GW'(PAT_LEN - 1);

  state_t                    st, st_nxt;
  logic [ADDR_W:0]           len_q;
  logic [PAT_LEN*DATA_W-1:0] pat_q;
  logic                      ovl_q;
  logic [HW-1:0]             hist, hist_nxt;
  logic [GW-1:0]             fill, guard;
  logic                      raw_eq, last, match;
`ifdef PTM_MASK_EN
  logic [PAT_LEN*DATA_W-1:0] mask_q;
`endif

  if (PAT_LEN > 2) begin : g_shift
    assign hist_nxt = {data, hist[HW-1:DATA_W]};
  end else begin : g_load
    assign hist_nxt = data;
  end

  ptm_window_cmp #(
    .DATA_W  (DATA_W),
    .PAT_LEN (PAT_LEN)
  ) u_cmp (
    .hist     (hist),
    .data     (data),
    .pattern  (pat_q),
`ifdef PTM_MASK_EN
    .pat_mask (mask_q),
`endif
    .eq       (raw_eq)
  );

  assign last  = ({1'b0, addr} == (len_q - (ADDR_W+1)'(1)));
  assign match = en && raw_eq && (fill == FILL_MAX) && (ovl_q || (guard == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start) st_nxt = (len == '0) ? DONE : SCAN;
      SCAN:    if (last) st_nxt = DONE;
      DONE:    if (!start) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    en   = (st == SCAN);
    fin  = (st == DONE);
    flag = match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      pat_q  <= '0;
      ovl_q  <= 1'b0;
      addr   <= '0;
      result <= '0;
      hist   <= '0;
      fill   <= '0;
      guard  <= '0;
`ifdef PTM_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      case (st)
        IDLE: if (start) begin
          len_q  <= len;
          pat_q  <= pattern;
          ovl_q  <= overlap;
          addr   <= '0;
          result <= '0;
          hist   <= '0;
          fill   <= '0;
          guard  <= '0;
`ifdef PTM_MASK_EN
          mask_q <= pat_mask;
`endif
        end
        SCAN: begin
          if (!last) addr <= addr + ADDR_W'(1);
          hist <= hist_nxt;
          if (fill != FILL_MAX) fill <= fill + GW'(1);
          if (match) result <= result + (ADDR_W+1)'(1);
          // Non-overlap: block the next PAT_LEN-1 addresses after a hit.
          if (match && !ovl_q)    guard <= FILL_MAX;
          else if (guard != '0)   guard <= guard - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ptm_window.sv
// tb/tb_ptm_window.sv - self-checking bench for ptm_window (honours PTM_MASK_EN)
module tb_ptm_window;

  localparam int DW = 10;
  localparam int AW = 10;
  localparam int P  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [P*DW-1:0] pattern;
`ifdef PTM_MASK_EN
  logic [P*DW-1:0] pat_mask;
`endif
  logic [AW:0]     len;
  logic            overlap;
  logic [DW-1:0]   data;
  logic            en;
  logic [AW-1:0]   addr;
  logic            flag;
  logic            fin;
  logic [AW:0]     result;

  logic [DW-1:0] mem      [0:1023];
  logic          exp_flag [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign data = mem[addr];

  ptm_window dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
`ifdef PTM_MASK_EN
    .pat_mask (pat_mask),
`endif
    .len      (len),
    .overlap  (overlap),
    .data     (data),
    .en       (en),
    .addr     (addr),
    .flag     (flag),
    .fin      (fin),
    .result   (result)
  );

  typedef struct {
    int              setup;
    int              n;
    logic [P*DW-1:0] pat;
    logic            ovl;
    logic [P*DW-1:0] msk;
    int              exp_res;
  } vec_t;

  vec_t vecs[$];

  localparam logic [P*DW-1:0] PAT_A = {10'h004, 10'h003, 10'h002, 10'h001};
  localparam logic [P*DW-1:0] PAT_7 = {10'h007, 10'h007, 10'h007, 10'h007};
  localparam logic [P*DW-1:0] PAT_M = {10'h040, 10'h030, 10'h020, 10'h010};
  localparam logic [P*DW-1:0] MSK_F = {10'h00F, 10'h00F, 10'h00F, 10'h00F};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic setup_mem(input int kind);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    case (kind)
      0: begin
        for (int k = 0; k < 4; k++) begin
          mem[3+k]  = DW'(k + 1);
          mem[10+k] = DW'(k + 1);
        end
      end
      1: for (int i = 0; i < 10; i++) mem[i] = 10'h007;
      2: for (int k = 0; k < 4; k++) mem[1020+k] = DW'(k + 1);
      3: begin
        mem[0] = 10'h01F; mem[1] = 10'h02A; mem[2] = 10'h033; mem[3] = 10'h045;
      end
      default: ;
    endcase
  endtask

  // Reference: a match at i needs the P words ending at i to equal the pattern
  // (masked bits ignored); without overlap it must start after the previous hit.
  task automatic run_model(input int n, input logic [P*DW-1:0] pat, input logic ovl,
                           input logic [P*DW-1:0] msk, output int cnt);
    int   last_hit;
    logic hit;
    cnt      = 0;
    last_hit = -P;
    for (int i = 0; i < n; i++) begin
      exp_flag[i] = 1'b0;
      if (i >= P - 1) begin
        hit = 1'b1;
        for (int k = 0; k < P; k++)
          if (((mem[i-P+1+k] ^ pat[k*DW +: DW]) & ~msk[k*DW +: DW]) != '0) hit = 1'b0;
        if (hit && (ovl || (i - last_hit >= P))) begin
          exp_flag[i] = 1'b1;
          cnt++;
          last_hit = i;
        end
      end
    end
  endtask

  task automatic do_scan(input int n, input logic [P*DW-1:0] pat, input logic ovl,
                         input logic [P*DW-1:0] msk, output logic [AW:0] got);
    int ecnt;
    run_model(n, pat, ovl, msk, ecnt);
    @(negedge clk);
    pattern = pat;
    len     = (AW+1)'(n);
    overlap = ovl;
`ifdef PTM_MASK_EN
    pat_mask = msk;
`endif
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("en[%0d]", i), en, 1);
      check($sformatf("addr[%0d]", i), addr, i);
      check($sformatf("flag[%0d]", i), flag, exp_flag[i]);
      check($sformatf("fin_early[%0d]", i), fin, 0);
    end
    @(negedge clk);
    check("fin_done", fin, 1);
    check("en_done", en, 0);
    check("flag_done", flag, 0);
    check("result", result, ecnt);
    if (n > 0) check("addr_hold", addr, n - 1);
    got = result;
    repeat (2) begin
      @(negedge clk);
      check("no_rescan_en", en, 0);
      check("no_rescan_fin", fin, 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_fin", fin, 0);
    check("idle_en", en, 0);
  endtask

  logic [AW:0]     got;
  int              rn, rj;
  logic [P*DW-1:0] rpat, rmsk;
  logic            rovl;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; overlap = 1'b0;
`ifdef PTM_MASK_EN
    pat_mask = '0;
`endif
    setup_mem(0);
    repeat (2) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_addr", addr, 0);
    check("rst_flag", flag, 0);
    check("rst_fin", fin, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    // Reset while idle with a held nonzero result.
    do_scan(16, PAT_A, 1'b1, '0, got);
    check("idle_result_held", result, 2);
    #2 rst = 1'b1;
    #1;
    check("idle_rst_result", result, 0);
    check("idle_rst_addr", addr, 0);
    check("idle_rst_fin", fin, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-scan at addr 5, effective without a clock edge.
    setup_mem(0);
    pattern = PAT_A; len = 11'd16; overlap = 1'b1; start = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_addr", addr, 5);
    check("pre_rst_en", en, 1);
    #2 rst = 1'b1;
    #1;
    check("scan_rst_en", en, 0);
    check("scan_rst_addr", addr, 0);
    check("scan_rst_flag", flag, 0);
    check("scan_rst_fin", fin, 0);
    check("scan_rst_result", result, 0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    vecs.push_back('{0, 16,   PAT_A, 1'b1, '0, 2});
    vecs.push_back('{1, 10,   PAT_7, 1'b1, '0, 7});
    vecs.push_back('{1, 10,   PAT_7, 1'b0, '0, 2});
    vecs.push_back('{0, 0,    PAT_A, 1'b1, '0, 0});
    vecs.push_back('{2, 1024, PAT_A, 1'b1, '0, 1});
    vecs.push_back('{3, 4,    PAT_M, 1'b1, '0, 0});
`ifdef PTM_MASK_EN
    vecs.push_back('{3, 4,    PAT_M, 1'b1, MSK_F, 1});
`endif
    for (int v = 0; v < vecs.size(); v++) begin
      setup_mem(vecs[v].setup);
      do_scan(vecs[v].n, vecs[v].pat, vecs[v].ovl, vecs[v].msk, got);
      check($sformatf("vec%0d_result", v), got, vecs[v].exp_res);
    end

    for (int r = 0; r < 10; r++) begin
      rn = $urandom_range(0, 48);
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      for (int i = 0; i < rn; i++) mem[i] = DW'($urandom_range(0, 2));
      for (int k = 0; k < P; k++) rpat[k*DW +: DW] = DW'($urandom_range(0, 2));
      if ((r % 2 == 1) && rn >= P) begin
        rj = $urandom_range(0, rn - P);
        for (int k = 0; k < P; k++) rpat[k*DW +: DW] = mem[rj+k];
      end
      rovl = 1'($urandom_range(0, 1));
      rmsk = '0;
`ifdef PTM_MASK_EN
      if (r % 3 == 0)
        for (int k = 0; k < P; k++) rmsk[k*DW +: DW] = DW'($urandom_range(0, 3));
`endif
      do_scan(rn, rpat, rovl, rmsk, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
